pll_phase_sequencer: RTL and testbench
======================================

Name: pll_phase_sequencer

Overview:
Converts the serial processor's PLL requests (updatepll strobe, pll_clk_src, pll_clk_phase) into the Cyclone III ALTPLL dynamic-control pin sequence: clkswitch pulses for input-source changes, and a phasestep/scanclk/phasedone handshake per phase step.
Tracks the PLL's current phase-step position and source, and walks it to the requested absolute value one step at a time.
Sits between the serial processor and the PLL instance in the top level.

Parameters:
SCAN_DIV, 4, scanclk half-period in clk cycles (>=2)
SWITCH_CYCLES, 8, clkswitch high width in clk cycles
SETTLE_CYCLES, 1024, wait after a source switch before any phase stepping
TIMEOUT_CYCLES, 4096, maximum clk cycles spent waiting on any single phasedone edge
COUNTER_SEL, 3'b000, value driven on phasecounterselect (000 = all counters)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
updatepll  in  1  one-cycle request strobe from the processor
pll_clk_src  in  1  requested PLL input clock (0 = inclk0)
pll_clk_phase  in  8  requested absolute phase position, in steps
phasedone  in  1  from PLL; asynchronous to clk; low while a step is in progress
phasecounterselect  out  3  to PLL
phaseupdown  out  1  to PLL; 1 = up, 0 = down
phasestep  out  1  to PLL
scanclk  out  1  to PLL
clkswitch  out  1  to PLL
busy  out  1  high whenever the state is not IDLE or a request is pending
current_phase  out  8  step position the PLL has reached
current_src  out  1  source the PLL is on
timeout_err  out  1  sticky; cleared by reset or by the next accepted request

Behaviour:
- Reset values: phasecounterselect=COUNTER_SEL, phaseupdown=1, phasestep=0, scanclk=0, clkswitch=0, busy=0, current_phase=0, current_src=0, timeout_err=0. Internal state: IDLE, no pending request.
- Reset mid-operation aborts immediately. No step-back is attempted.
- phasedone passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Request latch:
  - updatepll loads tgt_phase and tgt_src, and sets pending.
  - updatepll while busy overwrites tgt and pending (last request wins). It is acted on at the next step boundary.
  - Acceptance (pending cleared, timeout_err cleared) happens in IDLE, or at a step boundary.
- scanclk:
  - Toggles every SCAN_DIV clk cycles only in STEP, WAIT_LO and WAIT_HI.
  - Held 0 in all other states.
  - Its divider restarts at 0 when STEP is entered.
- IDLE:
  - If pending: accept.
  - If tgt_src != current_src: go to SWITCH.
  - Else if tgt_phase != current_phase: go to STEP.
  - Else: clear pending and stay in IDLE.
- SWITCH: clkswitch=1 for SWITCH_CYCLES cycles. Then current_src toggles and the state goes to SETTLE.
- SETTLE: SETTLE_CYCLES cycles with all PLL outputs idle. Then go to STEP if tgt_phase != current_phase, else IDLE.
- STEP:
  - On entry, phaseupdown = (tgt_phase > current_phase). Unsigned compare, no wrap: 0 -> 255 takes 255 up-steps.
  - phasestep is asserted on the clk cycle after a scanclk falling edge.
  - Then go to WAIT_LO.
- WAIT_LO:
  - When synchronized phasedone is seen low, deassert phasestep on the next scanclk-low cycle.
  - Then go to WAIT_HI.
- WAIT_HI:
  - When synchronized phasedone is seen high, current_phase increments (up) or decrements (down). This is the step boundary.
  - If pending: re-accept (src change goes to SWITCH).
  - Else if current_phase != tgt_phase: go to STEP.
  - Else: go to IDLE.
- Timeout:
  - WAIT_LO and WAIT_HI each have a counter that restarts on entry.
  - Reaching TIMEOUT_CYCLES sets timeout_err, forces phasestep=0, leaves current_phase unchanged, clears pending, and goes to IDLE.
- phaseupdown and phasecounterselect only change in IDLE or STEP entry, never while phasestep=1.
- busy = (state != IDLE) | pending. Rises the cycle after updatepll.

Test Plan:
- Reset, then updatepll with phase=3, src=0, and a PLL model (phasedone low 6 clk after phasestep, high 10 clk later) -> exactly 3 phasestep pulses, phaseupdown=1, current_phase ends 3, clkswitch never asserted, busy drops after the third step.
- From phase 3, request phase=1 -> 2 steps with phaseupdown=0, current_phase 3->2->1.
- Request src=1, phase=1 (phase unchanged) -> clkswitch high exactly 8 cycles, then 1024 idle cycles, current_src=1, no phasestep pulses.
- During a 0->10 walk, issue a second updatepll with phase=4 at step 6 -> the walk reverses at the boundary after current_phase=6 and ends at 4; no step is interrupted mid-handshake.
- PLL model never drops phasedone -> timeout_err=1 after 4096 cycles in WAIT_LO, phasestep=0, current_phase unchanged, busy=0. The next updatepll clears timeout_err.
- Assert reset while in WAIT_HI -> next cycle all outputs at reset values, current_phase=0.

Source files
------------

// File: rtl/pll_phase_sequencer.sv
// Sequences ALTPLL dynamic-control pins: clkswitch for source changes, then one
// phasestep/phasedone handshake per step until the PLL reaches the requested phase.
module pll_phase_sequencer #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned SWITCH_CYCLES  = 8,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [2:0]  COUNTER_SEL    = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       updatepll,
    input  logic       pll_clk_src,
    input  logic [7:0] pll_clk_phase,
    input  logic       phasedone,
    output logic [2:0] phasecounterselect,
    output logic       phaseupdown,
    output logic       phasestep,
    output logic       scanclk,
    output logic       clkswitch,
    output logic       busy,
    output logic [7:0] current_phase,
    output logic       current_src,
    output logic       timeout_err
);
    localparam int unsigned M1      = (SWITCH_CYCLES > SETTLE_CYCLES) ? SWITCH_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SWITCH, SETTLE, STEP, WAIT_LO, WAIT_HI} state_t;
    typedef struct packed {
        logic       src;
        logic [7:0] phase;
    } pll_req_t;

    state_t           state, state_n;
    pll_req_t         tgt;
    logic             pending, pending_n, accept;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic             scanclk_n, scanclk_q, lo_seen, lo_seen_n;
    logic [7:0]       phase_n;
    logic             src_n, dir_n, step_n, tmo_n;
    logic [1:0]       pd_sync;
    logic             pd_s, sc_fall, tmo_hit, enter_step, sc_active, sc_active_n;

    assign pd_s               = pd_sync[1];
    assign sc_fall            = scanclk_q & ~scanclk;
    assign tmo_hit            = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign phasecounterselect = COUNTER_SEL;
    assign clkswitch          = (state == SWITCH);
    assign busy               = (state != IDLE) | pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tgt           <= '0;
            pending       <= 1'b0;
            cnt           <= '0;
            div_cnt       <= '0;
            scanclk       <= 1'b0;
            scanclk_q     <= 1'b0;
            lo_seen       <= 1'b0;
            current_phase <= 8'd0;
            current_src   <= 1'b0;
            phaseupdown   <= 1'b1;
            phasestep     <= 1'b0;
            timeout_err   <= 1'b0;
            pd_sync       <= 2'b11;
        end else begin
            state         <= state_n;
            pending       <= pending_n;
            cnt           <= cnt_n;
            div_cnt       <= div_n;
            scanclk       <= scanclk_n;
            scanclk_q     <= scanclk;
            lo_seen       <= lo_seen_n;
            current_phase <= phase_n;
            current_src   <= src_n;
            phaseupdown   <= dir_n;
            phasestep     <= step_n;
            timeout_err   <= tmo_n;
            pd_sync       <= {pd_sync[0], phasedone};
            if (updatepll) tgt <= '{src: pll_clk_src, phase: pll_clk_phase};
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        accept    = 1'b0;
        cnt_n     = cnt + CNT_W'(1);
        lo_seen_n = lo_seen;
        phase_n   = current_phase;
        src_n     = current_src;
        dir_n     = phaseupdown;
        step_n    = phasestep;
        tmo_n     = timeout_err;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pending) begin
                    accept = 1'b1;
                    if (tgt.src != current_src)          state_n = SWITCH;
                    else if (tgt.phase != current_phase) state_n = STEP;
                end
            end
            SWITCH: if (cnt == CNT_W'(SWITCH_CYCLES - 1)) begin
                src_n   = ~current_src;
                state_n = SETTLE;
            end
            SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1))
                state_n = (tgt.phase != current_phase) ? STEP : IDLE;
            STEP: if (sc_fall) begin
                step_n  = 1'b1;
                state_n = WAIT_LO;
            end
            WAIT_LO: begin
                // Release phasestep only while scanclk is low, once the PLL has acknowledged.
                if ((lo_seen | ~pd_s) & ~scanclk) begin
                    step_n  = 1'b0;
                    state_n = WAIT_HI;
                end else if (tmo_hit) begin
                    tmo_n     = 1'b1;
                    step_n    = 1'b0;
                    pending_n = 1'b0;
                    state_n   = IDLE;
                end else if (~pd_s) begin
                    lo_seen_n = 1'b1;
                end
            end
            WAIT_HI: begin
                if (pd_s) begin
                    phase_n = phaseupdown ? current_phase + 8'd1 : current_phase - 8'd1;
                    accept  = pending;
                    if (pending && (tgt.src != current_src)) state_n = SWITCH;
                    else if (tgt.phase != phase_n)           state_n = STEP;
                    else                                     state_n = IDLE;
                end else if (tmo_hit) begin
                    tmo_n     = 1'b1;
                    pending_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            pending_n = 1'b0;
            tmo_n     = 1'b0;
        end
        // A strobe in the same cycle as acceptance stays pending for the next boundary.
        if (updatepll) pending_n = 1'b1;

        if (state_n != state) begin
            cnt_n     = '0;
            lo_seen_n = 1'b0;
        end

        enter_step = (state_n == STEP) && (state != STEP);
        if (enter_step) dir_n = (tgt.phase > phase_n);

        sc_active   = (state == STEP) || (state == WAIT_LO) || (state == WAIT_HI);
        sc_active_n = (state_n == STEP) || (state_n == WAIT_LO) || (state_n == WAIT_HI);
        if (enter_step) begin
            div_n     = '0;
            scanclk_n = scanclk;
        end else if (sc_active && sc_active_n) begin
            if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                div_n     = '0;
                scanclk_n = ~scanclk;
            end else begin
                div_n     = div_cnt + DIV_W'(1);
                scanclk_n = scanclk;
            end
        end else begin
            div_n     = '0;
            scanclk_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Bench for pll_phase_sequencer: PLL handshake model, per-cycle monitor, directed and random walks.
module tb_pll_phase_sequencer;
    localparam int SWITCH_CYCLES  = 8;
    localparam int SETTLE_CYCLES  = 1024;
    localparam int TIMEOUT_CYCLES = 4096;

    logic       clk = 1'b0, reset = 1'b1, updatepll = 1'b0, pll_clk_src = 1'b0;
    logic [7:0] pll_clk_phase = 8'd0;
    logic       phasedone;
    logic [2:0] phasecounterselect;
    logic       phaseupdown, phasestep, scanclk, clkswitch, busy, current_src, timeout_err;
    logic [7:0] current_phase;

    always #5 clk = ~clk;

    pll_phase_sequencer #(
        .SCAN_DIV(4), .SWITCH_CYCLES(SWITCH_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .COUNTER_SEL(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .updatepll(updatepll), .pll_clk_src(pll_clk_src),
        .pll_clk_phase(pll_clk_phase), .phasedone(phasedone),
        .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
        .phasestep(phasestep), .scanclk(scanclk), .clkswitch(clkswitch), .busy(busy),
        .current_phase(current_phase), .current_src(current_src), .timeout_err(timeout_err)
    );

    int checks = 0, errors = 0;
    int n_pulse = 0, n_up = 0, n_sw = 0, n_chg = 0, last_settle = 0, last_ps_len = 0;
    logic       pll_dead = 1'b0;
    logic [7:0] pll_pos;
    int         pll_t;
    logic       ps_q;

    // PLL: latches a step on phasestep rise, drops phasedone 6 clk later, raises it 10 clk after that.
    initial begin
        phasedone = 1'b1; pll_t = -1; pll_pos = 8'd0; ps_q = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                phasedone = 1'b1; pll_t = -1; pll_pos = 8'd0; ps_q = 1'b0;
            end else begin
                if (phasestep && !ps_q && !pll_dead) begin
                    pll_t   = 0;
                    pll_pos = phaseupdown ? pll_pos + 8'd1 : pll_pos - 8'd1;
                end else if (pll_t >= 0) pll_t++;
                if (pll_t == 6) phasedone = 1'b0;
                if (pll_t == 16) begin phasedone = 1'b1; pll_t = -1; end
                ps_q = phasestep;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Per-cycle compare process: protocol rules plus agreement with the PLL model's position.
    task automatic monitor();
        logic pps = 1'b0, pcs = 1'b0, pdir = 1'b1, in_settle = 1'b0;
        logic [7:0] pph = 8'd0, d;
        int sw_run = 0, ps_run = 0, settle_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pps = 1'b0; pcs = 1'b0; pph = 8'd0; sw_run = 0; ps_run = 0; in_settle = 1'b0;
            end else begin
                chk("pcsel", int'(phasecounterselect), 0);
                if (phasestep && !pps) begin n_pulse++; if (phaseupdown) n_up++; end
                if (phasestep && pps) chk("updown_stable", int'(phaseupdown), int'(pdir));
                if (clkswitch) begin n_sw++; chk("switch_quiet", int'({phasestep, scanclk}), 0); end
                if (!clkswitch && pcs) begin
                    chk("switch_width", sw_run, SWITCH_CYCLES);
                    in_settle = 1'b1; settle_run = 0;
                end
                if (in_settle) begin
                    if (busy && !phasestep && !scanclk) settle_run++;
                    else begin in_settle = 1'b0; last_settle = settle_run; end
                end
                if (current_phase != pph) begin
                    n_chg++;
                    d = current_phase - pph;
                    chk("phase_unit_step", int'(d == 8'd1 || d == 8'd255), 1);
                    chk("phase_vs_pll", int'(current_phase), int'(pll_pos));
                end
                if (!phasestep && pps) last_ps_len = ps_run;
                sw_run = clkswitch ? sw_run + 1 : 0;
                ps_run = phasestep ? ps_run + 1 : 0;
                pps = phasestep; pcs = clkswitch; pdir = phaseupdown; pph = current_phase;
            end
        end
    endtask

    task automatic request(input logic s, input logic [7:0] p);
        @(negedge clk); updatepll = 1'b1; pll_clk_src = s; pll_clk_phase = p;
        @(negedge clk); updatepll = 1'b0;
        chk("busy_rise", int'(busy), 1);
    endtask

    task automatic wait_idle(input int budget, output int maxp, output int minp);
        int n = 0;
        maxp = int'(current_phase); minp = int'(current_phase);
        while (busy && n < budget) begin
            @(negedge clk); n++;
            if (int'(current_phase) > maxp) maxp = int'(current_phase);
            if (int'(current_phase) < minp) minp = int'(current_phase);
        end
        chk("idle_reached", int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_outs"}, int'({phasecounterselect, phaseupdown, phasestep, scanclk,
                                  clkswitch, busy, current_src, timeout_err}), 64);
        chk({tag, "_phase"}, int'(current_phase), 0);
    endtask

    initial begin
        int b_p, b_u, b_s, b_c, mx, mn, n, d, tgt, steps, cur_p;
        logic s, cur_s;
        fork monitor(); join_none

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // 0 -> 3 upward
        b_p = n_pulse; b_u = n_up; b_s = n_sw; b_c = n_chg;
        request(1'b0, 8'd3); wait_idle(2000, mx, mn);
        chk("t1_pulses", n_pulse - b_p, 3); chk("t1_up", n_up - b_u, 3);
        chk("t1_phase", int'(current_phase), 3); chk("t1_switch", n_sw - b_s, 0);
        chk("t1_changes", n_chg - b_c, 3);

        // 3 -> 1 downward
        b_p = n_pulse; b_u = n_up;
        request(1'b0, 8'd1); wait_idle(2000, mx, mn);
        chk("t2_pulses", n_pulse - b_p, 2); chk("t2_up", n_up - b_u, 0);
        chk("t2_phase", int'(current_phase), 1); chk("t2_min", mn, 1); chk("t2_max", mx, 3);

        // source switch only
        b_p = n_pulse; b_s = n_sw;
        request(1'b1, 8'd1); wait_idle(3000, mx, mn);
        chk("t3_switch", n_sw - b_s, SWITCH_CYCLES); chk("t3_pulses", n_pulse - b_p, 0);
        chk("t3_src", int'(current_src), 1); chk("t3_settle", last_settle, SETTLE_CYCLES);
        chk("t3_phase", int'(current_phase), 1);

        // 0 -> 10 walk redirected to 4 during step 6
        request(1'b1, 8'd0); wait_idle(2000, mx, mn);
        chk("t4_start", int'(current_phase), 0);
        b_p = n_pulse; b_c = n_chg;
        request(1'b1, 8'd10);
        n = 0;
        while (!(current_phase == 8'd5 && phasestep) && n < 3000) begin @(negedge clk); n++; end
        chk("t4_reach5", int'(current_phase == 8'd5 && phasestep), 1);
        request(1'b1, 8'd4); wait_idle(3000, mx, mn);
        chk("t4_max", mx, 6); chk("t4_phase", int'(current_phase), 4);
        chk("t4_pulses", n_pulse - b_p, 8); chk("t4_changes", n_chg - b_c, 8);

        // dead PLL: timeout in WAIT_LO
        pll_dead = 1'b1; b_p = n_pulse;
        request(1'b1, 8'd5); wait_idle(TIMEOUT_CYCLES + 500, mx, mn);
        chk("t5_tmo", int'(timeout_err), 1); chk("t5_step", int'(phasestep), 0);
        chk("t5_phase", int'(current_phase), 4); chk("t5_busy", int'(busy), 0);
        chk("t5_step_len", last_ps_len, TIMEOUT_CYCLES); chk("t5_pulses", n_pulse - b_p, 1);
        pll_dead = 1'b0;
        request(1'b1, 8'd4);
        chk("t5_tmo_hold", int'(timeout_err), 1);
        wait_idle(200, mx, mn);
        chk("t5_tmo_clear", int'(timeout_err), 0);

        // random requests against the walk model
        cur_p = 4; cur_s = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d   = int'($urandom_range(0, 30)) - 15;
            tgt = cur_p + d;
            if (tgt < 0) tgt = 0;
            if (tgt > 255) tgt = 255;
            s     = ($urandom_range(0, 3) == 0) ? ~cur_s : cur_s;
            steps = (tgt > cur_p) ? tgt - cur_p : cur_p - tgt;
            b_p = n_pulse; b_u = n_up; b_s = n_sw; b_c = n_chg;
            request(s, 8'(tgt)); wait_idle(100 * steps + 2 * SETTLE_CYCLES + 500, mx, mn);
            chk("rnd_phase", int'(current_phase), tgt); chk("rnd_src", int'(current_src), int'(s));
            chk("rnd_pulses", n_pulse - b_p, steps); chk("rnd_changes", n_chg - b_c, steps);
            chk("rnd_up", n_up - b_u, (tgt > cur_p) ? steps : 0);
            chk("rnd_switch", n_sw - b_s, (s != cur_s) ? SWITCH_CYCLES : 0);
            chk("rnd_tmo", int'(timeout_err), 0);
            cur_p = tgt; cur_s = s;
        end

        // reset while waiting for phasedone high
        request(cur_s, 8'(cur_p + 3));
        n = 0;
        while (!phasestep && n < 500) begin @(negedge clk); n++; end
        while (phasestep && n < 1000) begin @(negedge clk); n++; end
        chk("t7_in_wait_hi", int'(n < 1000 && busy), 1);
        chk("t7_phase_held", int'(current_phase), cur_p);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t7_reset");
        reset = 1'b0;

        b_p = n_pulse; b_u = n_up;
        request(1'b0, 8'd2); wait_idle(2000, mx, mn);
        chk("t8_pulses", n_pulse - b_p, 2); chk("t8_up", n_up - b_u, 2);
        chk("t8_phase", int'(current_phase), 2); chk("t8_src", int'(current_src), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
